// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain: 8N1/8N2 UART transmitter draining a FWFT TX FIFO; define UART_TX_PARITY_EN for 8E/8O
module uart_tx_fifo_drain #(
  parameter int CLKS_PER_BIT = 1085,
  parameter int STOP_BITS = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_rd_data,
  output logic       fifo_rd_en,
  input  logic       tx_enable,
  input  logic       cts_n,
  output logic       uart_tx,
  output logic       tx_busy,
  output logic       frame_done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRE = CW'(CLKS_PER_BIT - 2);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
  if (CLKS_PER_BIT < 2 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_tx_fifo_drain: illegal parameter combination");
  end
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] sh;
`ifdef UART_TX_PARITY_EN
  logic par;
`endif
  logic bit_end;
  logic last_stop;
  // launch is only considered when idle or in the very last stop-bit cycle, so frames never get cut short
  always_comb begin
    bit_end = cnt == CNT_LAST;
    last_stop = state == STOP && idx == STOP_LAST && bit_end;
    fifo_rd_en = !rst && tx_enable && !fifo_empty && !cts_n && (state == IDLE || last_stop);
  end
  // frame sequencer with registered line, busy and done outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      uart_tx <= 1'b1;
      tx_busy <= 1'b0;
      frame_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      frame_done <= state == STOP && idx == STOP_LAST && cnt == CNT_PRE;
      if (fifo_rd_en) begin
        state <= START;
        cnt <= '0;
        idx <= '0;
        sh <= fifo_rd_data;
        uart_tx <= 1'b0;
        tx_busy <= 1'b1;
`ifdef UART_TX_PARITY_EN
        par <= ^fifo_rd_data ^ 1'(PARITY_ODD);
`endif
      end else if (state != IDLE) begin
        cnt <= bit_end ? '0 : cnt + CW'(1);
        if (bit_end) begin
          case (state)
            START: begin
              state <= DATA;
              uart_tx <= sh[0];
            end
            DATA: begin
              if (idx == 3'd7) begin
                idx <= '0;
`ifdef UART_TX_PARITY_EN
                state <= PARITY;
                uart_tx <= par;
`else
                state <= STOP;
                uart_tx <= 1'b1;
`endif
              end else begin
                idx <= idx + 3'd1;
                sh <= sh >> 1;
                uart_tx <= sh[1];
              end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
              state <= STOP;
              uart_tx <= 1'b1;
            end
`endif
            STOP: begin
              if (idx == STOP_LAST) begin
                state <= IDLE;
                idx <= '0;
                tx_busy <= 1'b0;
              end else begin
                idx <= idx + 3'd1;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end
endmodule

// File: doc/uart_tx_fifo_drain.md
Name: uart_tx_fifo_drain

Overview:
UART transmitter that drains the 64-deep TX sync FIFO of the UART-AXI4 bridge and serialises each byte onto the uart_tx pin as 8N1 or 8N2 (8 data bits, no parity, 1 or 2 stop bits). It sits directly downstream of the TX FIFO and uses that FIFO's first-word-fall-through (combinational) read data and its empty flag. CTS flow control holds off new frames; a frame already in progress always completes.

Parameters:
CLKS_PER_BIT, 1085, clk cycles per UART bit (125 MHz / 115200); must be >= 2.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; only used when UART_TX_PARITY_EN is defined.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
fifo_empty  in  1  TX FIFO empty flag
fifo_rd_data  in  8  TX FIFO head data, valid whenever fifo_empty=0
fifo_rd_en  out  1  pop strobe to the TX FIFO
tx_enable  in  1  allows new frames to start
cts_n  in  1  clear-to-send, active low; already synchronised upstream
uart_tx  out  1  serial line; idles high
tx_busy  out  1  high while a frame is in progress
frame_done  out  1  one-cycle pulse in the last cycle of a stop bit

Behaviour:
- Reset and clock: reset rst, synchronous, active-high; clock clk. Reset values: uart_tx=1, tx_busy=0, frame_done=0, fifo_rd_en=0, FSM=IDLE, baud counter=0, bit index=0.
- Launch condition L = tx_enable & !fifo_empty & !cts_n.
- L is evaluated only in IDLE, or in the final cycle of the last stop bit.
- fifo_rd_en is combinational and equals L in those cycles; otherwise it is 0. It is never high when fifo_empty=1.
- In the cycle fifo_rd_en=1, fifo_rd_data is captured into the shift register and the FSM moves to START.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE: uart_tx=1, tx_busy=0.
  - START: uart_tx=0.
  - DATA: shift register drives uart_tx, LSB first, 8 bits; bit index 0..7.
  - PARITY: present only with the macro.
  - STOP: uart_tx=1 for STOP_BITS bits.
- Bit timing: each bit is held exactly CLKS_PER_BIT cycles. The baud counter counts 0..CLKS_PER_BIT-1 and is $clog2(CLKS_PER_BIT) bits wide. A bit advances when the counter equals CLKS_PER_BIT-1.
- Latency: uart_tx falls in the cycle after fifo_rd_en=1.
- Frame length is exactly (1+8+P+STOP_BITS)*CLKS_PER_BIT cycles, where P=1 with parity, 0 without.
- tx_busy is high from the first START cycle through the last STOP cycle inclusive.
- frame_done is high in the last STOP cycle.
- Back-to-back frames: if L is true in the last STOP cycle, the next frame's START follows immediately, with no idle cycle and tx_busy held high. Otherwise the FSM returns to IDLE.
- Mid-frame changes to tx_enable, cts_n or fifo_empty: ignored; the frame completes.
- rst mid-frame: the next cycle shows reset values. The byte being sent is dropped; it is not re-read.
- fifo_rd_data is not sampled outside the load cycle.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: a PARITY bit is inserted between DATA and STOP. Its value is XOR of the 8 data bits, inverted when PARITY_ODD=1. Frame becomes 8E/8O.
- Not defined: no PARITY state exists and PARITY_ODD is ignored. Frame length excludes the parity bit.

Test Plan:
All scenarios use CLKS_PER_BIT=4 and STOP_BITS=1 unless stated.

1. Reset: hold rst=1 for 5 cycles with fifo_empty=0, tx_enable=1, cts_n=0 -> uart_tx=1, fifo_rd_en=0, tx_busy=0 throughout.
2. Single byte: FIFO holds 0xA5; release rst -> fifo_rd_en high for exactly 1 cycle, then uart_tx = 0,1,0,1,0,0,1,0,1,1 (each held 4 cycles). frame_done pulses in cycle 40 of the frame, then the FSM returns to IDLE.
3. Back-to-back: FIFO holds 0x00 then 0xFF -> fifo_rd_en pulses exactly 40 cycles apart. The second start bit begins directly after the first stop bit. tx_busy stays high for 80 consecutive cycles.
4. Flow control:
   - cts_n=1 with 0x3C queued -> no fifo_rd_en, uart_tx=1 for 100 cycles.
   - Drop cts_n -> frame starts.
   - Raise cts_n in data bit 3 -> the frame completes and no second pop occurs.
5. Reset mid-frame: assert rst for 1 cycle during data bit 4 of 0x81 -> uart_tx=1 and tx_busy=0 on the next cycle. After release with a second byte 0x55 queued, 0x55 is transmitted intact and 0x81 is not resent.
6. Parity (UART_TX_PARITY_EN defined, PARITY_ODD=0): send 0x07 -> parity bit=1 and frame length 44 cycles. With PARITY_ODD=1 -> parity bit=0. With the macro undefined -> frame length 40 cycles.
